// File: rtl/al_alarm_sequencer.sv
// Timekeeping and alarm sequencer: 24-hour BCD clock, validated time/alarm loads,
// and the ARMED/RINGING/SNOOZE state machine that drives the buzzer.
module al_alarm_sequencer #(
   parameter int ALARM_DURATION_S = 60,
   parameter int SNOOZE_S         = 300
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        one_second,
   input  logic [15:0] key_buffer,
   input  logic        load_alarm,
   input  logic        load_new_time,
   input  logic        alarm_enable,
   input  logic        snooze,
   input  logic        alarm_off,
   output logic [15:0] cur_time,
   output logic [7:0]  cur_seconds,
   output logic [15:0] alarm_time,
   output logic        sound_alarm,
   output logic        load_error,
   output logic [1:0]  debug_state_out
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARMED   = 2'd1;
   localparam logic [1:0] RINGING = 2'd2;
   localparam logic [1:0] SNOOZE  = 2'd3;

   logic [15:0] cur_time_q, cur_time_d;
   logic [7:0]  cur_seconds_q, cur_seconds_d;
   logic [15:0] alarm_time_q, alarm_time_d;
   logic [1:0]  state_q, state_d;
   logic [9:0]  timer_q, timer_d;
   logic        load_error_q, load_error_d;
   logic        sound_alarm_q, sound_alarm_d;

   logic        key_valid;
   logic        time_load_ok;
   logic        tick;
   logic        match;
   logic [23:0] time_inc;

   function automatic logic valid_hhmm(input logic [15:0] v);
      valid_hhmm = (v[15:12] <= 4'd2) && (v[11:8] <= 4'd9) &&
                   (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9) &&
                   !((v[15:12] == 4'd2) && (v[11:8] > 4'd3));
   endfunction

   // BCD HHMMSS increment with 23:59:59 -> 00:00:00 wrap.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [3:0] ht, hu, mt, mu, st, su;
      {ht, hu, mt, mu, st, su} = t;
      if (su != 4'd9) su = su + 4'd1;
      else begin
         su = 4'd0;
         if (st != 4'd5) st = st + 4'd1;
         else begin
            st = 4'd0;
            if (mu != 4'd9) mu = mu + 4'd1;
            else begin
               mu = 4'd0;
               if (mt != 4'd5) mt = mt + 4'd1;
               else begin
                  mt = 4'd0;
                  if ((ht == 4'd2) && (hu == 4'd3)) begin
                     ht = 4'd0;
                     hu = 4'd0;
                  end else if (hu != 4'd9) hu = hu + 4'd1;
                  else begin
                     hu = 4'd0;
                     ht = ht + 4'd1;
                  end
               end
            end
         end
      end
      bcd_inc = {ht, hu, mt, mu, st, su};
   endfunction

   always_comb begin
      key_valid     = valid_hhmm(key_buffer);
      time_load_ok  = load_new_time && key_valid;
      tick          = one_second && !time_load_ok;
      time_inc      = bcd_inc({cur_time_q, cur_seconds_q});
      match         = tick && (time_inc[7:0] == 8'h00) && (time_inc[23:8] == alarm_time_q);

      cur_time_d    = cur_time_q;
      cur_seconds_d = cur_seconds_q;
      alarm_time_d  = alarm_time_q;
      state_d       = state_q;
      timer_d       = timer_q;
      load_error_d  = (load_alarm || load_new_time) && !key_valid;

      if (time_load_ok) begin
         cur_time_d    = key_buffer;
         cur_seconds_d = 8'h00;
      end else if (tick) begin
         {cur_time_d, cur_seconds_d} = time_inc;
      end

      if (load_alarm && key_valid) alarm_time_d = key_buffer;

      if (!alarm_enable) begin
         state_d = IDLE;
         timer_d = 10'd0;
      end else begin
         case (state_q)
            IDLE: state_d = ARMED;
            ARMED: begin
               if (match) begin
                  state_d = RINGING;
                  timer_d = 10'(ALARM_DURATION_S);
               end
            end
            RINGING: begin
               if (alarm_off) state_d = ARMED;
               else if (snooze) begin
                  state_d = SNOOZE;
                  timer_d = 10'(SNOOZE_S);
               end else if (one_second && (timer_q != 10'd0)) begin
                  timer_d = timer_q - 10'd1;
                  if (timer_q == 10'd1) state_d = ARMED;
               end
            end
            SNOOZE: begin
               if (alarm_off) state_d = ARMED;
               else if (one_second && (timer_q != 10'd0)) begin
                  if (timer_q == 10'd1) begin
                     state_d = RINGING;
                     timer_d = 10'(ALARM_DURATION_S);
                  end else begin
                     timer_d = timer_q - 10'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      sound_alarm_d = (state_d == RINGING);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur_time_q    <= 16'h0000;
         cur_seconds_q <= 8'h00;
         alarm_time_q  <= 16'h0000;
         state_q       <= IDLE;
         timer_q       <= 10'd0;
         load_error_q  <= 1'b0;
         sound_alarm_q <= 1'b0;
      end else begin
         cur_time_q    <= cur_time_d;
         cur_seconds_q <= cur_seconds_d;
         alarm_time_q  <= alarm_time_d;
         state_q       <= state_d;
         timer_q       <= timer_d;
         load_error_q  <= load_error_d;
         sound_alarm_q <= sound_alarm_d;
      end
   end

   assign cur_time        = cur_time_q;
   assign cur_seconds     = cur_seconds_q;
   assign alarm_time      = alarm_time_q;
   assign sound_alarm     = sound_alarm_q;
   assign load_error      = load_error_q;
   assign debug_state_out = state_q;

endmodule

// File: tb/tb_al_alarm_sequencer.sv
// Directed bench for al_alarm_sequencer: time counting, load validation,
// ring/snooze/off sequencing, enable override and asynchronous reset.
module tb_al_alarm_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        one_second = 1'b0;
   logic [15:0] key_buffer = 16'h0000;
   logic        load_alarm = 1'b0;
   logic        load_new_time = 1'b0;
   logic        alarm_enable = 1'b0;
   logic        snooze = 1'b0;
   logic        alarm_off = 1'b0;
   logic [15:0] cur_time;
   logic [7:0]  cur_seconds;
   logic [15:0] alarm_time;
   logic        sound_alarm;
   logic        load_error;
   logic [1:0]  debug_state_out;

   int checks = 0;
   int errors = 0;

   al_alarm_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .one_second      (one_second),
      .key_buffer      (key_buffer),
      .load_alarm      (load_alarm),
      .load_new_time   (load_new_time),
      .alarm_enable    (alarm_enable),
      .snooze          (snooze),
      .alarm_off       (alarm_off),
      .cur_time        (cur_time),
      .cur_seconds     (cur_seconds),
      .alarm_time      (alarm_time),
      .sound_alarm     (sound_alarm),
      .load_error      (load_error),
      .debug_state_out (debug_state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         one_second = 1'b1;
         @(negedge clk);
         one_second = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic load_time(input logic [15:0] v);
      key_buffer    = v;
      load_new_time = 1'b1;
      @(negedge clk);
      load_new_time = 1'b0;
   endtask

   task automatic load_alm(input logic [15:0] v);
      key_buffer = v;
      load_alarm = 1'b1;
      @(negedge clk);
      load_alarm = 1'b0;
   endtask

   task automatic pulse_snooze();
      snooze = 1'b1;
      @(negedge clk);
      snooze = 1'b0;
   endtask

   task automatic pulse_off();
      alarm_off = 1'b1;
      @(negedge clk);
      alarm_off = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_time", 32'(cur_time), 32'h0000);
      chk("rst_sec", 32'(cur_seconds), 32'h00);
      chk("rst_alarm", 32'(alarm_time), 32'h0000);
      chk("rst_sound", 32'(sound_alarm), 32'h0);
      chk("rst_lerr", 32'(load_error), 32'h0);
      chk("rst_state", 32'(debug_state_out), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // midnight rollover
      load_time(16'h2359);
      chk("ld2359_time", 32'(cur_time), 32'h2359);
      chk("ld2359_lerr", 32'(load_error), 32'h0);
      ticks(61);
      chk("wrap_time", 32'(cur_time), 32'h0000);
      chk("wrap_sec", 32'(cur_seconds), 32'h01);
      chk("wrap_lerr", 32'(load_error), 32'h0);

      // rejected loads
      load_time(16'h2460);
      chk("bad_time_lerr", 32'(load_error), 32'h1);
      chk("bad_time_keep", 32'(cur_time), 32'h0000);
      @(negedge clk);
      chk("bad_time_lerr_end", 32'(load_error), 32'h0);
      load_alm(16'h12A0);
      chk("bad_alm_lerr", 32'(load_error), 32'h1);
      chk("bad_alm_keep", 32'(alarm_time), 32'h0000);
      @(negedge clk);
      chk("bad_alm_lerr_end", 32'(load_error), 32'h0);

      // simultaneous loads: valid alarm applied, bad time rejected
      key_buffer = 16'h0700;
      load_alarm = 1'b1;
      @(negedge clk);
      load_alarm = 1'b0;
      key_buffer = 16'h1960;
      load_alarm = 1'b1;
      load_new_time = 1'b1;
      @(negedge clk);
      load_alarm = 1'b0;
      load_new_time = 1'b0;
      chk("dual_alarm", 32'(alarm_time), 32'h0700);
      chk("dual_time", 32'(cur_time), 32'h0000);
      chk("dual_lerr", 32'(load_error), 32'h1);

      // ring at 07:00:00, auto-stop after ALARM_DURATION_S
      load_time(16'h0659);
      alarm_enable = 1'b1;
      @(negedge clk);
      chk("armed", 32'(debug_state_out), 32'h1);
      ticks(59);
      chk("pre_ring_state", 32'(debug_state_out), 32'h1);
      chk("pre_ring_sound", 32'(sound_alarm), 32'h0);
      ticks(1);
      chk("ring_sound", 32'(sound_alarm), 32'h1);
      chk("ring_state", 32'(debug_state_out), 32'h2);
      chk("ring_time", 32'(cur_time), 32'h0700);
      ticks(59);
      chk("ring59_state", 32'(debug_state_out), 32'h2);
      ticks(1);
      chk("autostop_state", 32'(debug_state_out), 32'h1);
      chk("autostop_sound", 32'(sound_alarm), 32'h0);

      // snooze, re-ring, alarm_off
      load_time(16'h0659);
      ticks(60);
      chk("ring2_state", 32'(debug_state_out), 32'h2);
      pulse_snooze();
      chk("snz_state", 32'(debug_state_out), 32'h3);
      chk("snz_sound", 32'(sound_alarm), 32'h0);
      pulse_snooze();
      chk("snz_ignored", 32'(debug_state_out), 32'h3);
      ticks(299);
      chk("snz299_state", 32'(debug_state_out), 32'h3);
      ticks(1);
      chk("rering_state", 32'(debug_state_out), 32'h2);
      chk("rering_sound", 32'(sound_alarm), 32'h1);
      pulse_off();
      chk("off_state", 32'(debug_state_out), 32'h1);
      chk("off_sound", 32'(sound_alarm), 32'h0);

      // a time load onto the alarm time does not ring
      load_time(16'h0700);
      chk("ldmatch_state", 32'(debug_state_out), 32'h1);
      ticks(1);
      chk("ldmatch_tick_state", 32'(debug_state_out), 32'h1);
      chk("ldmatch_sec", 32'(cur_seconds), 32'h01);

      // disable while ringing
      load_time(16'h0659);
      ticks(60);
      chk("ring3_state", 32'(debug_state_out), 32'h2);
      alarm_enable = 1'b0;
      @(negedge clk);
      chk("disable_state", 32'(debug_state_out), 32'h0);
      chk("disable_sound", 32'(sound_alarm), 32'h0);

      // load wins over a same-cycle second tick
      ticks(3);
      key_buffer    = 16'h1000;
      load_new_time = 1'b1;
      one_second    = 1'b1;
      @(negedge clk);
      load_new_time = 1'b0;
      one_second    = 1'b0;
      chk("ldtick_time", 32'(cur_time), 32'h1000);
      chk("ldtick_sec", 32'(cur_seconds), 32'h00);

      // asynchronous reset mid-ring
      alarm_enable = 1'b1;
      load_time(16'h0659);
      ticks(60);
      chk("ring4_state", 32'(debug_state_out), 32'h2);
      #2 reset = 1'b0;
      #1;
      chk("areset_sound", 32'(sound_alarm), 32'h0);
      chk("areset_state", 32'(debug_state_out), 32'h0);
      chk("areset_time", 32'(cur_time), 32'h0000);
      chk("areset_sec", 32'(cur_seconds), 32'h00);
      chk("areset_alarm", 32'(alarm_time), 32'h0000);
      chk("areset_lerr", 32'(load_error), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
